// File: rtl/ram64_arbiter.sv
// ram64_arbiter: shares one port of the 1024x64 byte-write DFFRAM between two
// requesters using round-robin priority with bounded burst locking, and
// returns read data with a per-requester valid strobe one cycle after grant.
module ram64_arbiter #(
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 64,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic            CLK,
  input  logic            RST,
  // requester 0
  input  logic            req0,
  input  logic            lock0,
  input  logic [DW/8-1:0] we0,
  input  logic [AW-1:0]   a0,
  input  logic [DW-1:0]   di0,
  output logic            gnt0,
  output logic            rvalid0,
  output logic [DW-1:0]   rdata0,
  // requester 1
  input  logic            req1,
  input  logic            lock1,
  input  logic [DW/8-1:0] we1,
  input  logic [AW-1:0]   a1,
  input  logic [DW-1:0]   di1,
  output logic            gnt1,
  output logic            rvalid1,
  output logic [DW-1:0]   rdata1,
  // RAM macro port
  output logic            ram_en,
  output logic [DW/8-1:0] ram_we,
  output logic [AW-1:0]   ram_a,
  output logic [DW-1:0]   ram_di,
  input  logic [DW-1:0]   ram_do
);

  localparam int unsigned BW       = DW / 8;
  localparam int unsigned CW       = 4;
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  // arbitration state
  logic          rr_last;      // last port granted
  logic          lock_owner;   // port holding the current burst
  logic          lock_active;
  logic [CW-1:0] burst_cnt;

  logic          any_gnt;
  logic          gnt_port;     // index of the granted port when any_gnt
  logic          gnt_lock;     // lock hint of the granted port
  logic          lock_hold;    // owner may keep the RAM this cycle

  // A running burst holds priority until it has used MAX_BURST grants.
  assign lock_hold = lock_active && (burst_cnt < BURST_MAX);

  // Combinational grant; nothing is issued while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RST) begin
      if (req0 && !req1) begin
        gnt0 = 1'b1;
      end else if (req1 && !req0) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (lock_hold) begin
          gnt0 = ~lock_owner;
          gnt1 = lock_owner;
        end else begin
          // grant the port that did not win last time
          gnt0 = rr_last;
          gnt1 = ~rr_last;
        end
      end
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign gnt_port = gnt1;
  assign gnt_lock = gnt1 ? lock1 : (gnt0 & lock0);

  // RAM drive is muxed from the granted port, zero when idle.
  always_comb begin
    ram_en = any_gnt;
    ram_we = '0;
    ram_a  = '0;
    ram_di = '0;
    if (gnt0) begin
      ram_we = we0;
      ram_a  = a0;
      ram_di = di0;
    end else if (gnt1) begin
      ram_we = we1;
      ram_a  = a1;
      ram_di = di1;
    end
  end

  // Read data is shared; the rvalid strobes qualify ownership.
  assign rdata0 = ram_do;
  assign rdata1 = ram_do;

  // Round-robin pointer, burst lock tracking and read-valid pipeline.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_last     <= 1'b1;
      lock_owner  <= 1'b0;
      lock_active <= 1'b0;
      burst_cnt   <= '0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
    end else begin
      rvalid0 <= gnt0 && (we0 == BW'(0));
      rvalid1 <= gnt1 && (we1 == BW'(0));
      if (any_gnt) begin
        rr_last <= gnt_port;
        if (gnt_lock) begin
          if (lock_active && (lock_owner == gnt_port)) begin
            if (burst_cnt < BURST_MAX) begin
              burst_cnt <= burst_cnt + CW'(1);
            end
          end else begin
            lock_active <= 1'b1;
            lock_owner  <= gnt_port;
            burst_cnt   <= CW'(1);
          end
        end else begin
          lock_active <= 1'b0;
          burst_cnt   <= '0;
        end
      end else begin
        lock_active <= 1'b0;
        burst_cnt   <= '0;
      end
    end
  end

endmodule
